// File: rtl/fp_packet_parser.sv
// Fingerprint-link packet parser: hunts EF 01, checks address/length/checksum, streams payload bytes.
// Latency 1 clk from i_Rx_DV to any strobe; no backpressure, one byte consumed per i_Rx_DV.
module fp_packet_parser #(
    parameter logic [31:0] DEV_ADDR     = 32'hFFFFFFFF,
    parameter int          MAX_DATA     = 256,
    parameter int          TIMEOUT_CLKS = 3480
) (
    input  logic        i_Clock,
    input  logic        i_Reset,
    input  logic        i_Rx_DV,
    input  logic [7:0]  i_Rx_Byte,
    output logic        o_Data_DV,
    output logic [7:0]  o_Data_Byte,
    output logic [15:0] o_Data_Idx,
    output logic [7:0]  o_Pid,
    output logic [15:0] o_Len,
    output logic        o_Pkt_Done,
    output logic        o_Pkt_Err,
    output logic [2:0]  o_Err_Code
);

    typedef enum logic [3:0] {
        S_HDR0,
        S_HDR1,
        S_ADDR,
        S_PID,
        S_LEN_H,
        S_LEN_L,
        S_DATA,
        S_SUM_H,
        S_SUM_L
    } state_t;

    localparam int            TW        = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
    localparam logic [TW-1:0] IDLE_LAST = TW'(TIMEOUT_CLKS - 1);
    localparam logic [16:0]   LEN_MAX   = 17'(MAX_DATA + 2);
    localparam logic [2:0]    ERR_ADDR  = 3'd1;
    localparam logic [2:0]    ERR_LEN   = 3'd2;
    localparam logic [2:0]    ERR_SUM   = 3'd3;
    localparam logic [2:0]    ERR_TMO   = 3'd4;

    state_t        state_q;
    logic [1:0]    addr_idx_q;
    logic [7:0]    pid_q;
    logic [7:0]    sum_hi_q;
    logic [15:0]   len_q;
    logic [15:0]   sum_q;
    logic [15:0]   data_idx_q;
    logic [TW-1:0] idle_q;

    logic [15:0]   len_d;
    logic [15:0]   sum_d;
    logic [15:0]   last_idx_d;
    logic [7:0]    addr_byte_d;
    logic          len_bad_d;
    logic          sum_ok_d;

    always_comb begin
        len_d      = {len_q[7:0], i_Rx_Byte};
        sum_d      = sum_q + {8'h00, i_Rx_Byte};
        last_idx_d = len_q - 16'd3;
        sum_ok_d   = ({sum_hi_q, i_Rx_Byte} == sum_q);
        len_bad_d  = (len_d < 16'd2) || ({1'b0, len_d} > LEN_MAX);
        case (addr_idx_q)
            2'd0:    addr_byte_d = DEV_ADDR[31:24];
            2'd1:    addr_byte_d = DEV_ADDR[23:16];
            2'd2:    addr_byte_d = DEV_ADDR[15:8];
            default: addr_byte_d = DEV_ADDR[7:0];
        endcase
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state_q     <= S_HDR0;
            addr_idx_q  <= '0;
            pid_q       <= '0;
            sum_hi_q    <= '0;
            len_q       <= '0;
            sum_q       <= '0;
            data_idx_q  <= '0;
            idle_q      <= '0;
            o_Data_DV   <= 1'b0;
            o_Data_Byte <= '0;
            o_Data_Idx  <= '0;
            o_Pid       <= '0;
            o_Len       <= '0;
            o_Pkt_Done  <= 1'b0;
            o_Pkt_Err   <= 1'b0;
            o_Err_Code  <= '0;
        end else begin
            o_Data_DV  <= 1'b0;
            o_Pkt_Done <= 1'b0;
            o_Pkt_Err  <= 1'b0;
            if (i_Rx_DV) begin
                // A byte on the expiry cycle takes priority over the timeout.
                idle_q <= '0;
                case (state_q)
                    S_HDR0: begin
                        if (i_Rx_Byte == 8'hEF) state_q <= S_HDR1;
                    end
                    S_HDR1: begin
                        if (i_Rx_Byte == 8'h01) begin
                            state_q    <= S_ADDR;
                            addr_idx_q <= 2'd0;
                        end else if (i_Rx_Byte != 8'hEF) begin
                            state_q <= S_HDR0;
                        end
                    end
                    S_ADDR: begin
                        addr_idx_q <= addr_idx_q + 2'd1;
                        if (i_Rx_Byte != addr_byte_d) begin
                            o_Pkt_Err  <= 1'b1;
                            o_Err_Code <= ERR_ADDR;
                            state_q    <= S_HDR0;
                        end else if (addr_idx_q == 2'd3) begin
                            state_q <= S_PID;
                        end
                    end
                    S_PID: begin
                        pid_q   <= i_Rx_Byte;
                        sum_q   <= {8'h00, i_Rx_Byte};
                        state_q <= S_LEN_H;
                    end
                    S_LEN_H: begin
                        len_q   <= {8'h00, i_Rx_Byte};
                        sum_q   <= sum_d;
                        state_q <= S_LEN_L;
                    end
                    S_LEN_L: begin
                        len_q      <= len_d;
                        sum_q      <= sum_d;
                        data_idx_q <= '0;
                        if (len_bad_d) begin
                            o_Pkt_Err  <= 1'b1;
                            o_Err_Code <= ERR_LEN;
                            state_q    <= S_HDR0;
                        end else if (len_d == 16'd2) begin
                            state_q <= S_SUM_H;
                        end else begin
                            state_q <= S_DATA;
                        end
                    end
                    S_DATA: begin
                        o_Data_DV   <= 1'b1;
                        o_Data_Byte <= i_Rx_Byte;
                        o_Data_Idx  <= data_idx_q;
                        sum_q       <= sum_d;
                        data_idx_q  <= data_idx_q + 16'd1;
                        if (data_idx_q == last_idx_d) state_q <= S_SUM_H;
                    end
                    S_SUM_H: begin
                        sum_hi_q <= i_Rx_Byte;
                        state_q  <= S_SUM_L;
                    end
                    S_SUM_L: begin
                        // Published fields move only on a good packet.
                        if (sum_ok_d) begin
                            o_Pkt_Done <= 1'b1;
                            o_Pid      <= pid_q;
                            o_Len      <= len_q;
                        end else begin
                            o_Pkt_Err  <= 1'b1;
                            o_Err_Code <= ERR_SUM;
                        end
                        state_q <= S_HDR0;
                    end
                    default: state_q <= S_HDR0;
                endcase
            end else if (state_q != S_HDR0) begin
                if (idle_q == IDLE_LAST) begin
                    o_Pkt_Err  <= 1'b1;
                    o_Err_Code <= ERR_TMO;
                    state_q    <= S_HDR0;
                    idle_q     <= '0;
                end else begin
                    idle_q <= idle_q + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_fp_packet_parser.sv
// Scoreboard bench for fp_packet_parser: packet-level generator pushes expected strobes,
// an independent negedge monitor pops and compares every strobe the parser emits.
`timescale 1ns/1ps
module tb_fp_packet_parser;

    localparam int TMO      = 100;
    localparam int MAX_DATA = 256;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        dv  = 1'b0;
    logic [7:0]  rxb = 8'h00;
    logic        o_Data_DV;
    logic [7:0]  o_Data_Byte;
    logic [15:0] o_Data_Idx;
    logic [7:0]  o_Pid;
    logic [15:0] o_Len;
    logic        o_Pkt_Done;
    logic        o_Pkt_Err;
    logic [2:0]  o_Err_Code;

    fp_packet_parser #(
        .DEV_ADDR    (32'hFFFFFFFF),
        .MAX_DATA    (MAX_DATA),
        .TIMEOUT_CLKS(TMO)
    ) dut (
        .i_Clock    (clk),
        .i_Reset    (rst),
        .i_Rx_DV    (dv),
        .i_Rx_Byte  (rxb),
        .o_Data_DV  (o_Data_DV),
        .o_Data_Byte(o_Data_Byte),
        .o_Data_Idx (o_Data_Idx),
        .o_Pid      (o_Pid),
        .o_Len      (o_Len),
        .o_Pkt_Done (o_Pkt_Done),
        .o_Pkt_Err  (o_Pkt_Err),
        .o_Err_Code (o_Err_Code)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // kind: 1 data strobe, 2 packet done, 3 packet error
    typedef struct {
        int          kind;
        logic [31:0] f1;
        logic [31:0] f2;
        int          cyc;
    } ev_t;

    ev_t        expq[$];
    int         errors = 0;
    int         checks = 0;
    logic [7:0] held_pid = 8'h00;
    logic [15:0] held_len = 16'h0000;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic exp_at(input int k, input int f1, input int f2, input int c);
        ev_t e;
        e.kind = k;
        e.f1   = f1;
        e.f2   = f2;
        e.cyc  = c;
        expq.push_back(e);
    endtask

    // The byte driven now is sampled on the next edge; its strobe is visible after that edge.
    task automatic exp_ev(input int k, input int f1, input int f2);
        exp_at(k, f1, f2, cyc + 1);
    endtask

    task automatic send(input logic [7:0] b);
        dv  = 1'b1;
        rxb = b;
        @(negedge clk);
        dv  = 1'b0;
    endtask

    task automatic gapw(input bit gap);
        if (gap) repeat ($urandom_range(0, 3)) @(negedge clk);
    endtask

    task automatic tx(input logic [7:0] b, input bit gap);
        gapw(gap);
        send(b);
    endtask

    task automatic noise(input int n);
        logic [7:0] b;
        for (int i = 0; i < n; i++) begin
            b = 8'($urandom_range(0, 253));
            if (b >= 8'hEF) b = b + 8'd1;
            tx(b, 1'b1);
        end
    endtask

    task automatic packet(input bit bad_addr, input int len_ovr, input int ndata,
                          input logic [7:0] pid, input bit gap, input bit zero_data,
                          input logic [15:0] sum_xor);
        int          n;
        int          bad_pos;
        logic [15:0] len;
        logic [15:0] sum;
        logic [7:0]  d;
        bit          len_err;
        n       = ndata;
        len     = (len_ovr >= 0) ? 16'(len_ovr) : 16'(ndata + 2);
        len_err = (len < 16'd2) || (int'(len) - 2 > MAX_DATA);
        if (!len_err) n = int'(len) - 2;
        bad_pos = bad_addr ? int'($urandom_range(0, 3)) : 4;
        tx(8'hEF, gap);
        tx(8'h01, gap);
        for (int i = 0; i < 4; i++) begin
            if (i == bad_pos) begin
                d = 8'($urandom_range(0, 254));
                gapw(gap);
                exp_ev(3, 1, 0);
                send(d);
                return;
            end
            tx(8'hFF, gap);
        end
        sum = 16'(pid) + 16'(len[15:8]) + 16'(len[7:0]);
        tx(pid, gap);
        tx(len[15:8], gap);
        gapw(gap);
        if (len_err) begin
            exp_ev(3, 2, 0);
            send(len[7:0]);
            return;
        end
        send(len[7:0]);
        for (int i = 0; i < n; i++) begin
            d   = zero_data ? 8'h00 : 8'($urandom);
            sum = sum + 16'(d);
            gapw(gap);
            exp_ev(1, int'(d), i);
            send(d);
        end
        sum = sum ^ sum_xor;
        tx(sum[15:8], gap);
        gapw(gap);
        if (sum_xor != 16'h0000) exp_ev(3, 3, 0);
        else                     exp_ev(2, int'(pid), int'(len));
        send(sum[7:0]);
    endtask

    always @(negedge clk) begin
        ev_t         e;
        logic [31:0] k;
        logic [31:0] f1;
        logic [31:0] f2;
        if (o_Pkt_Done && o_Pkt_Err) check("done_err_exclusive", 64'd1, 64'd0);
        if (o_Data_DV || o_Pkt_Done || o_Pkt_Err) begin
            if (o_Pkt_Done) begin
                k = 2; f1 = 32'(o_Pid); f2 = 32'(o_Len);
            end else if (o_Pkt_Err) begin
                k = 3; f1 = 32'(o_Err_Code); f2 = 0;
            end else begin
                k = 1; f1 = 32'(o_Data_Byte); f2 = 32'(o_Data_Idx);
            end
            if (expq.size() == 0) begin
                check("unexpected_strobe_kind", 64'(k), 64'd0);
            end else begin
                e = expq.pop_front();
                check("strobe_kind", 64'(k), 64'(e.kind));
                check("strobe_field1", 64'(f1), 64'(e.f1));
                check("strobe_field2", 64'(f2), 64'(e.f2));
                check("strobe_cycle", 64'(cyc), 64'(e.cyc));
                if (e.kind == 2) begin
                    held_pid = e.f1[7:0];
                    held_len = e.f2[15:0];
                end
                if (e.kind == 3) check("held_pid_len", 64'({o_Pid, o_Len}), 64'({held_pid, held_len}));
            end
        end
    end

    initial begin
        logic [7:0] pid;
        int         r;
        int         nd;

        repeat (3) @(negedge clk);
        check("reset_state", 64'({o_Data_DV, o_Pkt_Done, o_Pkt_Err, o_Err_Code, o_Pid, o_Len,
                                  o_Data_Byte, o_Data_Idx}), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Good packet, then the same packet with a corrupted checksum low byte (0A -> 0B)
        packet(1'b0, -1, 1, 8'h07, 1'b0, 1'b1, 16'h0000);
        packet(1'b0, -1, 1, 8'h07, 1'b0, 1'b1, 16'h0001);

        // Address mismatch on the last address byte, trailing junk, then recovery
        send(8'hEF); send(8'h01); send(8'hFF); send(8'hFF); send(8'hFF);
        exp_ev(3, 1, 0);
        send(8'hFE);
        send(8'h12); send(8'h34); send(8'h56); send(8'h78); send(8'h9A);
        packet(1'b0, -1, 4, 8'h33, 1'b1, 1'b0, 16'h0000);

        // Length limits: too short, one past max, zero-length payload, exactly max
        packet(1'b0, 1, 0, 8'h07, 1'b0, 1'b0, 16'h0000);
        packet(1'b0, 259, 0, 8'h07, 1'b0, 1'b0, 16'h0000);
        packet(1'b0, -1, 0, 8'h07, 1'b0, 1'b0, 16'h0000);
        packet(1'b0, -1, MAX_DATA, 8'h44, 1'b0, 1'b0, 16'h0000);

        // Timeout fires exactly TMO cycles after the last byte
        send(8'hEF); send(8'h01); send(8'hFF);
        exp_at(3, 4, 0, cyc + TMO);
        repeat (TMO + 20) @(negedge clk);

        // A byte landing on the expiry cycle suppresses the timeout
        send(8'hEF); send(8'h01); send(8'hFF);
        repeat (TMO - 1) @(negedge clk);
        send(8'hFF); send(8'hFF); send(8'hFF);
        send(8'h07); send(8'h00); send(8'h02); send(8'h00);
        exp_ev(2, 8'h07, 2);
        send(8'h09);
        repeat (5) @(negedge clk);

        // Header hunting through noise: 00 EF EF 01 ...
        send(8'h00); send(8'hEF);
        packet(1'b0, -1, 2, 8'h5C, 1'b0, 1'b0, 16'h0000);

        // Reset on data byte 1 of a LEN=0005 packet
        send(8'hEF); send(8'h01);
        send(8'hFF); send(8'hFF); send(8'hFF); send(8'hFF);
        send(8'h21); send(8'h00); send(8'h05);
        exp_ev(1, 8'h5A, 0);
        send(8'h5A);
        @(negedge clk);
        rst = 1'b1;
        dv  = 1'b1;
        rxb = 8'hA5;
        @(negedge clk);
        rst = 1'b0;
        dv  = 1'b0;
        held_pid = 8'h00;
        held_len = 16'h0000;
        check("outputs_after_midpacket_reset",
              64'({o_Data_DV, o_Pkt_Done, o_Pkt_Err, o_Err_Code, o_Pid, o_Len, o_Data_Byte, o_Data_Idx}),
              64'd0);
        packet(1'b0, -1, 3, 8'h66, 1'b1, 1'b0, 16'h0000);

        // Randomized mix of good and faulty packets separated by non-EF noise
        for (int p = 0; p < 40; p++) begin
            r   = int'($urandom_range(0, 9));
            pid = 8'($urandom);
            nd  = int'($urandom_range(0, 24));
            case (r)
                6:       packet(1'b0, -1, nd, pid, 1'b1, 1'b0, 16'($urandom_range(1, 65535)));
                7:       packet(1'b1, -1, nd, pid, 1'b1, 1'b0, 16'h0000);
                8:       packet(1'b0, int'($urandom_range(0, 1)), nd, pid, 1'b1, 1'b0, 16'h0000);
                9:       packet(1'b0, int'($urandom_range(259, 65535)), nd, pid, 1'b1, 1'b0, 16'h0000);
                default: packet(1'b0, -1, nd, pid, 1'b1, 1'b0, 16'h0000);
            endcase
            noise(int'($urandom_range(0, 3)));
        end

        for (int i = 0; i < 200 && expq.size() != 0; i++) @(negedge clk);
        if (expq.size() != 0) check("expected_strobes_outstanding", 64'(expq.size()), 64'd0);
        repeat (5) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fp_packet_parser.md
Name: fp_packet_parser

Overview:
Byte-level packet parser for the fingerprint sensor link. It consumes the received-byte stream (data-valid pulse plus byte) from the UART receiver and delineates sensor packets in the format: header EF 01, 4-byte address, PID, 2-byte LEN, LEN-2 data bytes, 2-byte checksum. Data bytes are streamed out with their index. Each packet ends in exactly one done pulse or one error pulse, which the command/match controller downstream consumes.

Parameters:
DEV_ADDR, 32'hFFFFFFFF, expected module address, compared MSB first.
MAX_DATA, 256, maximum accepted data bytes per packet (LEN-2).
TIMEOUT_CLKS, 3480, idle clocks allowed between bytes mid-packet (about 4 byte times at 87 clks/bit).

Ports:
i_Clock  input  1  system clock
i_Reset  input  1  synchronous, active-high reset
i_Rx_DV  input  1  one-cycle strobe: i_Rx_Byte valid
i_Rx_Byte  input  8  received byte
o_Data_DV  output  1  one-cycle strobe: data byte valid
o_Data_Byte  output  8  payload byte
o_Data_Idx  output  16  payload byte index, 0-based
o_Pid  output  8  PID of the last completed packet
o_Len  output  16  LEN field of the last completed packet
o_Pkt_Done  output  1  one-cycle strobe: packet good
o_Pkt_Err  output  1  one-cycle strobe: packet aborted
o_Err_Code  output  3  0 none, 1 address, 2 length, 3 checksum, 4 timeout; valid with o_Pkt_Err and held until the next error

Behaviour:
- Clock and reset: single clock domain. Reset is synchronous and active-high. Reset drives state to S_HDR0 and zeroes every output and internal counter. Reset mid-packet discards the partial packet and produces no pulse.
- Byte acceptance: bytes are consumed only on cycles where i_Rx_DV=1. All strobe outputs are registered and fire on the cycle after the i_Rx_DV that causes them (latency 1).
- States and transitions:
  - S_HDR0: byte EF -> S_HDR1; any other byte -> stay.
  - S_HDR1: 01 -> S_ADDR; EF -> stay in S_HDR1; any other byte -> S_HDR0. Header hunting never raises an error.
  - S_ADDR: 4 bytes, compared against DEV_ADDR[31:24] down to [7:0]. On the first mismatching byte: error code 1, go to S_HDR0.
  - S_PID: latch PID into a shadow register; checksum = byte -> S_LEN_H.
  - S_LEN_H, S_LEN_L: capture LEN MSB first; add each byte to the checksum. Then:
    - LEN<2 or LEN-2>MAX_DATA: error code 2, go to S_HDR0.
    - LEN==2: -> S_SUM_H.
    - otherwise: -> S_DATA.
  - S_DATA: each byte pulses o_Data_DV with o_Data_Byte and o_Data_Idx (0..LEN-3), and is added to the checksum. After index LEN-3 -> S_SUM_H.
  - S_SUM_H, S_SUM_L: receive the checksum MSB first.
    - Match: o_Pkt_Done; o_Pid and o_Len updated from the shadow registers on the same cycle.
    - Mismatch: error code 3.
    - Either case -> S_HDR0.
- Checksum: 16-bit, wraps modulo 2^16. It is the sum of the PID, both LEN bytes and all data bytes; header and address bytes are excluded.
- Field holding: o_Pid and o_Len change only on o_Pkt_Done, so an erroring packet never corrupts them.
- Timeout: the idle counter runs in every state except S_HDR0 and clears on each i_Rx_DV. After TIMEOUT_CLKS consecutive idle cycles: error code 4, go to S_HDR0.
  - If i_Rx_DV arrives on the expiry cycle, the byte wins and no timeout fires.
- Exclusivity: o_Pkt_Done and o_Pkt_Err are never asserted together, and each packet yields at most one of them.

Test Plan:
1. Good packet: EF 01 FF FF FF FF 07 00 03 00 00 0A -> one o_Data_DV with byte 00, idx 0; then o_Pkt_Done; o_Pid=07, o_Len=0003, o_Pkt_Err never asserted.
2. Bad checksum: same stream with last byte 0B -> no o_Pkt_Done; o_Pkt_Err with code 3; o_Pid and o_Len keep their prior values.
3. Address mismatch and resync: EF 01 FF FF FF FE, then 5 arbitrary bytes, then a good packet -> error code 1 on the 6th byte; arbitrary bytes ignored; good packet then completes.
4. Length errors: LEN=0001 -> code 2. LEN=0103 with MAX_DATA=256 -> code 2. LEN=0002 with checksum 0009 -> done with zero data strobes.
5. Timeout: TIMEOUT_CLKS=100; send EF 01 FF, then idle -> o_Pkt_Err code 4 exactly 100 cycles after the last i_Rx_DV. A byte arriving at cycle 100 -> no error.
6. Noise and reset: 00 EF EF 01 + valid packet -> parsed correctly. Assert i_Reset at data byte 1 of a LEN=0005 packet -> all outputs 0, no pulse; next valid packet parsed.
